aes_decrypt_iter: RTL

//  Iterative AES inverse cipher (FIPS-197 5.3): one round per clock, valid/ready in and out.

---
 rtl/aes_decrypt_iter.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher: one round per clock, one block in flight.
// Also holds the shared KeyExpansion (round keys rk0 in MSBs ... rkNr in LSBs).

module aes_key_expansion #(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = 10
) (
    input  logic [32*Nk-1:0]      key_i,
    output logic [128*(Nr+1)-1:0] fullkeys_o
);
    localparam int unsigned NW = 4 * (Nr + 1);
    localparam int unsigned KW = 128 * (Nr + 1);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] o;
        for (int k = 0; k < 4; k++)
            o[31-8*k -: 8] = SBOX[2047-8*int'(w[31-8*k -: 8]) -: 8];
        return o;
    endfunction

    logic [31:0] w [NW];
    logic [31:0] t;
    logic [7:0]  rcon;

    // Standard word-wise expansion, then pack four words per round key
    always_comb begin
        t          = '0;
        rcon       = 8'h01;
        fullkeys_o = '0;
        for (int i = 0; i < int'(NW); i++) begin
            if (i < int'(Nk)) begin
                w[i] = key_i[32*Nk-1-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % int'(Nk) == 0) begin
                    t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                    rcon = xtime(rcon);
                end else if (Nk > 6 && i % int'(Nk) == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-int'(Nk)] ^ t;
            end
        end
        for (int r = 0; r <= int'(Nr); r++)
            fullkeys_o[KW-1-128*r -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
endmodule

module aes_decrypt_iter #(
    parameter int unsigned N  = 128,
    parameter int unsigned Nr = 10,
    parameter int unsigned Nk = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [127:0]   in_data,
    input  logic [N-1:0]   in_key,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   out_data,
    output logic           busy
);
    localparam int unsigned KW = 128 * (Nr + 1);
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int k = 0; k < 16; k++)
            o[127-8*k -: 8] = INV_SBOX[2047-8*int'(s[127-8*k -: 8]) -: 8];
        return o;
    endfunction

    // Row r of the column-major state rotates right by r positions
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        logic [7:0]   m9 [4], mb [4], md [4], me [4];
        logic [7:0]   x2, x4, x8;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]  = s[127-8*(4*c+r) -: 8];
                x2    = xtime(a[r]);
                x4    = xtime(x2);
                x8    = xtime(x4);
                m9[r] = x8 ^ a[r];
                mb[r] = x8 ^ x2 ^ a[r];
                md[r] = x8 ^ x4 ^ a[r];
                me[r] = x8 ^ x4 ^ x2;
            end
            o[127-32*c -: 32] = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                                 m9[0] ^ me[1] ^ mb[2] ^ md[3],
                                 md[0] ^ m9[1] ^ me[2] ^ mb[3],
                                 mb[0] ^ md[1] ^ m9[2] ^ me[3]};
        end
        return o;
    endfunction

    state_t         state_q, state_d;
    logic [127:0]   st_q, st_d;
    logic [N-1:0]   key_q, key_d;
    logic [3:0]     rnd_q, rnd_d;
    logic [127:0]   out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic           in_ready_q, in_ready_d;
    logic           busy_q, busy_d;
    logic [KW-1:0]  fullkeys;
    logic [3:0]     rk_idx;
    logic [127:0]   rk_sel;

    aes_key_expansion #(.Nk(Nk), .Nr(Nr)) u_key_exp (
        .key_i      (key_q),
        .fullkeys_o (fullkeys)
    );

    // Registered state, datapath and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            st_q        <= '0;
            key_q       <= '0;
            rnd_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            key_q       <= key_d;
            rnd_q       <= rnd_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state: IDLE accepts, DONE waits for the downstream handshake
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = INIT;
            INIT:    state_d = ROUND;
            ROUND:   if (rnd_q == 4'd1) state_d = FINAL;
            FINAL:   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Round key for the current step: rkNr in INIT, rk[rnd] in ROUND, rk0 in FINAL
    always_comb begin
        rk_idx = 4'd0;
        if (state_q == INIT)  rk_idx = 4'(Nr);
        if (state_q == ROUND) rk_idx = rnd_q;
        rk_sel = fullkeys[KW-1-128*int'(rk_idx) -: 128];
    end

    // Datapath and next-output values per state
    always_comb begin
        st_d        = st_q;
        key_d       = key_q;
        rnd_d       = rnd_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: if (in_valid) begin
                st_d  = in_data;
                key_d = in_key;
            end
            INIT: begin
                st_d  = st_q ^ rk_sel;
                rnd_d = 4'(Nr - 1);
            end
            ROUND: begin
                st_d  = inv_mix_columns(inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_sel);
                rnd_d = rnd_q - 4'd1;
            end
            FINAL: begin
                out_data_d  = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_sel;
                out_valid_d = 1'b1;
            end
            DONE: if (out_ready) out_valid_d = 1'b0;
            default: ;
        endcase
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d == ROUND) || (state_d == FINAL) || (state_d == DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
endmodule
